// File: rtl/frame_egress.sv
// Frame buffer reader: takes one committed-frame descriptor, positions the buffer read
// pointer and streams the frame's words out of a backpressured AXI-stream port, or drops it.
module frame_egress #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SKID_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH:0]   desc_start_ptr,
  input  logic [ADDR_WIDTH:0]   desc_end_ptr,
  input  logic                  desc_drop,
  output logic                  frame_ren,
  output logic                  frame_rrst,
  output logic [ADDR_WIDTH:0]   frame_rst_rptr,
  input  logic [ADDR_WIDTH:0]   frame_rptr,
  input  logic [19:0]           frame_rdata,
  output logic [15:0]           egress_tdata,
  output logic                  egress_tvalid,
  input  logic                  egress_tready,
  output logic                  egress_tlast,
  output logic                  frame_done
);
  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned EW = 17;
  localparam int unsigned SW = EW * SKID_DEPTH;

  typedef enum logic [2:0] {IDLE, SEEK, STREAM, DRAIN, DROP} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]           start_q, end_q, len_q, issued_q;
  logic [PW-1:0]           desc_len;
  logic [READ_LATENCY-1:0] pipe_vld, pipe_last;
  logic [CW-1:0]           skid_cnt, wpos;
  logic [SW-1:0]           skid_q, skid_nxt;
  logic                    accept, pop, push, done_nxt;
  int unsigned             inflight;
  logic [3:0]              unused_rsvd;

  assign unused_rsvd   = frame_rdata[19:16];
  assign desc_len      = desc_end_ptr - desc_start_ptr;
  assign accept        = desc_valid & desc_ready;
  assign pop           = egress_tvalid & egress_tready;
  assign push          = pipe_vld[READ_LATENCY-1];
  assign egress_tvalid = (skid_cnt != '0);
  assign egress_tdata  = skid_q[15:0];
  assign egress_tlast  = skid_q[16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Reads are issued only while every in-flight word is guaranteed a skid slot;
  // counting this cycle's pop keeps the stream bubble-free at SKID_DEPTH = READ_LATENCY+1.
  always_comb begin
    state_nxt      = state;
    desc_ready     = 1'b0;
    frame_ren      = 1'b0;
    frame_rrst     = 1'b0;
    frame_rst_rptr = '0;
    done_nxt       = 1'b0;
    inflight       = 32'($countones(pipe_vld));
    unique case (state)
      IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          if (desc_drop || desc_len == '0)      state_nxt = DROP;
          else if (frame_rptr != desc_start_ptr) state_nxt = SEEK;
          else                                   state_nxt = STREAM;
        end
      end
      SEEK: begin
        frame_rrst     = 1'b1;
        frame_rst_rptr = start_q;
        state_nxt      = STREAM;
      end
      STREAM: begin
        if (issued_q == len_q)
          state_nxt = DRAIN;
        else if (32'(skid_cnt) + inflight < SKID_DEPTH + 32'(pop))
          frame_ren = 1'b1;
      end
      DRAIN: begin
        if (pop && egress_tlast) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        frame_rrst     = 1'b1;
        frame_rst_rptr = end_q;
        done_nxt       = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Skid is a shift queue: head sits in the low entry, unused entries stay zero.
  always_comb begin
    wpos     = skid_cnt - CW'(pop);
    skid_nxt = pop ? (skid_q >> EW) : skid_q;
    if (push)
      skid_nxt = skid_nxt | (SW'({pipe_last[READ_LATENCY-1], frame_rdata[15:0]}) << (32'(wpos) * EW));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= '0;
      end_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
      skid_q     <= '0;
      skid_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      if (accept) begin
        start_q  <= desc_start_ptr;
        end_q    <= desc_end_ptr;
        len_q    <= desc_len;
        issued_q <= '0;
      end else if (frame_ren) begin
        issued_q <= issued_q + PW'(1);
      end
      pipe_vld  <= (pipe_vld << 1) | READ_LATENCY'(frame_ren);
      pipe_last <= (pipe_last << 1) | READ_LATENCY'(frame_ren && (issued_q == len_q - PW'(1)));
      skid_q    <= skid_nxt;
      skid_cnt  <= skid_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_frame_egress.sv
// Scoreboard bench for frame_egress: a buffer model feeds read data, expected words are
// queued when a descriptor is issued and popped by a monitor on every egress handshake.
module tb_frame_egress;
  localparam int unsigned A  = 11;
  localparam int unsigned PW = A + 1;
  localparam int unsigned RL = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          desc_valid, desc_ready, desc_drop;
  logic [A:0]    desc_start_ptr, desc_end_ptr;
  logic          frame_ren, frame_rrst;
  logic [A:0]    frame_rst_rptr;
  logic [A:0]    buf_rptr = '0;
  logic [19:0]   buf_rdata = '0;
  logic [15:0]   egress_tdata;
  logic          egress_tvalid, egress_tready, egress_tlast, frame_done;
  logic          tb_load = 1'b0;
  logic [A:0]    tb_load_val = '0;

  always #5 clk = ~clk;

  frame_egress #(.ADDR_WIDTH(A), .READ_LATENCY(RL), .SKID_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_start_ptr(desc_start_ptr), .desc_end_ptr(desc_end_ptr), .desc_drop(desc_drop),
    .frame_ren(frame_ren), .frame_rrst(frame_rrst), .frame_rst_rptr(frame_rst_rptr),
    .frame_rptr(buf_rptr), .frame_rdata(buf_rdata),
    .egress_tdata(egress_tdata), .egress_tvalid(egress_tvalid), .egress_tready(egress_tready),
    .egress_tlast(egress_tlast), .frame_done(frame_done)
  );

  function automatic logic [15:0] pat(input logic [A:0] p);
    return (16'(p[A-1:0]) * 16'd97) ^ 16'h3C5A;
  endfunction

  // Buffer read port model: one-cycle read latency, reserved bits deliberately nonzero.
  always @(posedge clk) begin
    if (tb_load) buf_rptr <= tb_load_val;
    else if (frame_rrst) buf_rptr <= frame_rst_rptr;
    else if (frame_ren) begin
      buf_rdata <= {4'hA, pat(buf_rptr)};
      buf_rptr  <= buf_rptr + PW'(1);
    end
  end

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] exp_q[$];
  int          done_cnt = 0, rrst_cnt = 0, valid_cycles = 0, words_seen = 0;
  int          last_hs_cyc = 0, done_cyc = 0, acc_cyc = 0;
  logic [A:0]  last_rst_rptr = '0;
  logic        drop_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, i.e. what the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {egress_tvalid, egress_tlast, egress_tdata}, {1'b1, prev_word});
      if (egress_tvalid) valid_cycles++;
      if (egress_tvalid && egress_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word got=%0h exp=none", {egress_tlast, egress_tdata});
        end else begin
          check("word", {egress_tlast, egress_tdata}, exp_q.pop_front());
        end
        words_seen++;
        if (egress_tlast) last_hs_cyc = cyc;
      end
      if (frame_rrst) begin
        rrst_cnt++;
        last_rst_rptr = frame_rst_rptr;
        check("rrst_ren_excl", frame_ren, 0);
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!drop_mode) begin
          check("done_after_last", cyc, last_hs_cyc + 1);
          check("ready_with_done", desc_ready, 1);
        end
      end
      prev_stall = egress_tvalid & ~egress_tready;
      prev_word  = {egress_tlast, egress_tdata};
    end
  end

  task automatic send(input logic [A:0] s, input logic [A:0] e, input logic drop);
    int n = 0;
    int len;
    logic [A:0] l;
    @(negedge clk);
    while (!desc_ready && n < 200) begin @(negedge clk); n++; end
    if (!desc_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL desc_ready_timeout got=0 exp=1");
    end
    l   = e - s;
    len = int'(l);
    if (!drop)
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pat(s + PW'(i))});
    desc_start_ptr = s;
    desc_end_ptr   = e;
    desc_drop      = drop;
    desc_valid     = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
    check("frame_done_count", done_cnt, target);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    desc_valid = 1'b0; desc_drop = 1'b0; desc_start_ptr = '0; desc_end_ptr = '0;
    egress_tready = 1'b1;
    #12;
    check("rst_ctrl", {desc_ready, frame_ren, frame_rrst, egress_tvalid, egress_tlast, frame_done}, 6'b100000);
    check("rst_rptr", frame_rst_rptr, 0);
    check("rst_tdata", egress_tdata, 0);
    @(negedge clk) reset_n = 1'b1;

    // 32-word frame, read pointer already at start
    valid_cycles = 0; rrst_cnt = 0;
    send(12'd0, 12'd32, 1'b0);
    n = 0;
    while (!egress_tvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("first_tvalid_latency", n, RL + 1);
    wait_done(1);
    check("t1_no_seek", rrst_cnt, 0);
    check("t1_no_bubbles", valid_cycles, 32);

    // single-word frame needing a seek
    @(posedge clk); #1; tb_load = 1'b1; tb_load_val = 12'd5;
    @(posedge clk); #1; tb_load = 1'b0;
    rrst_cnt = 0;
    send(12'd40, 12'd41, 1'b0);
    wait_done(2);
    check("t2_rrst_cnt", rrst_cnt, 1);
    check("t2_rst_rptr", last_rst_rptr, 40);

    // frame spanning the pointer wrap
    rrst_cnt = 0;
    send(12'd4090, 12'd10, 1'b0);
    wait_done(3);
    check("t3_rrst_cnt", rrst_cnt, 1);
    check("t3_rst_rptr", last_rst_rptr, 4090);

    // 20 words with tready toggling every cycle
    send(12'd200, 12'd220, 1'b0);
    n = 0;
    while (done_cnt < 4 && n < 500) begin @(posedge clk); #1; egress_tready = ~egress_tready; n++; end
    egress_tready = 1'b1;
    wait_done(4);

    // explicit drop
    drop_mode = 1'b1; valid_cycles = 0; rrst_cnt = 0;
    send(12'd100, 12'd164, 1'b1);
    wait_done(5);
    check("t5_rrst_cnt", rrst_cnt, 1);
    check("t5_rst_rptr", last_rst_rptr, 164);
    check("t5_no_tvalid", valid_cycles, 0);
    check("t5_done_delay", done_cyc - acc_cyc, 2);

    // zero-length frame behaves as a drop
    send(12'd7, 12'd7, 1'b0);
    wait_done(6);
    check("t5b_no_tvalid", valid_cycles, 0);
    drop_mode = 1'b0;

    // reset in the middle of a 64-word frame
    words_seen = 0;
    send(12'd300, 12'd364, 1'b0);
    n = 0;
    while (words_seen < 10 && n < 200) begin @(negedge clk); n++; end
    check("t6_words_before_reset", words_seen, 10);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_ctrl", {desc_ready, frame_ren, frame_rrst, egress_tvalid, egress_tlast, frame_done}, 6'b100000);
    check("t6_async_data", {frame_rst_rptr, egress_tdata}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_after_release", {desc_ready, egress_tvalid}, 2'b10);
    send(12'd0, 12'd8, 1'b0);
    wait_done(7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
